// File: rtl/cfg_regs.sv
// cfg_regs: configuration register block (CTRL, STATUS, SCRATCH, EVT_CNT, PARAM[]).
// Define CFG_REGS_EVT_CNT_EN to build the clear-on-read event counter at address 3.
module cfg_regs #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int NUM_PARAM  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CFG_DWIDTH-1:0]           cfg_wr_data,
    input  logic [CFG_AWIDTH-1:0]           cfg_wr_addr,
    input  logic                            cfg_wr_en,
    output logic [CFG_DWIDTH-1:0]           cfg_rd_data,
    input  logic [CFG_AWIDTH-1:0]           cfg_rd_addr,
    input  logic                            cfg_rd_en,
    output logic                            ctrl_enable,
    output logic                            ctrl_start,
    input  logic                            stat_busy,
    input  logic                            stat_done,
    input  logic                            evt_in,
    output logic [NUM_PARAM*CFG_DWIDTH-1:0] param_out
);
    localparam logic [CFG_AWIDTH-1:0] A_CTRL = CFG_AWIDTH'(0);
    localparam logic [CFG_AWIDTH-1:0] A_STAT = CFG_AWIDTH'(1);
    localparam logic [CFG_AWIDTH-1:0] A_SCR  = CFG_AWIDTH'(2);
    localparam logic [CFG_AWIDTH-1:0] A_EVT  = CFG_AWIDTH'(3);

    logic                                 ctrl_enable_q;
    logic                                 ctrl_start_q;
    logic                                 done_sticky;
    logic [CFG_DWIDTH-1:0]                scratch_q;
    logic [CFG_DWIDTH-1:0]                evt_cnt;
    logic [CFG_DWIDTH-1:0]                rd_mux;
    logic [CFG_DWIDTH-1:0]                rd_data_q;
    logic [NUM_PARAM-1:0][CFG_DWIDTH-1:0] param_q;
    logic                                 wr_ctrl;
    logic                                 wr_stat;
    logic                                 wr_scr;

    assign wr_ctrl = cfg_wr_en && (cfg_wr_addr == A_CTRL);
    assign wr_stat = cfg_wr_en && (cfg_wr_addr == A_STAT);
    assign wr_scr  = cfg_wr_en && (cfg_wr_addr == A_SCR);

    // start is re-derived every cycle, so back-to-back writes give one cycle each
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_enable_q <= 1'b0;
            ctrl_start_q  <= 1'b0;
        end else begin
            ctrl_start_q <= wr_ctrl && cfg_wr_data[1];
            if (wr_ctrl)
                ctrl_enable_q <= cfg_wr_data[0];
        end
    end

    // set wins over a coincident W1C
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            done_sticky <= 1'b0;
        else if (stat_done)
            done_sticky <= 1'b1;
        else if (wr_stat && cfg_wr_data[0])
            done_sticky <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch_q <= '0;
            param_q   <= '0;
        end else begin
            if (wr_scr)
                scratch_q <= cfg_wr_data;
            for (int i = 0; i < NUM_PARAM; i++)
                if (cfg_wr_en && (cfg_wr_addr == CFG_AWIDTH'(4 + i)))
                    param_q[i] <= cfg_wr_data;
        end
    end

`ifdef CFG_REGS_EVT_CNT_EN
    logic rd_evt;
    assign rd_evt = cfg_rd_en && (cfg_rd_addr == A_EVT);

    // a clearing read still counts the event seen in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            evt_cnt <= '0;
        else if (rd_evt)
            evt_cnt <= CFG_DWIDTH'(evt_in);
        else if (evt_in && (evt_cnt != '1))
            evt_cnt <= evt_cnt + CFG_DWIDTH'(1);
    end
`else
    logic unused_evt_in;
    assign unused_evt_in = evt_in;
    assign evt_cnt       = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (cfg_rd_addr)
            A_CTRL: rd_mux[0] = ctrl_enable_q;
            A_STAT: begin
                rd_mux[0] = done_sticky;
                rd_mux[1] = stat_busy;
            end
            A_SCR:  rd_mux = scratch_q;
            A_EVT:  rd_mux = evt_cnt;
            default: begin
                for (int i = 0; i < NUM_PARAM; i++)
                    if (cfg_rd_addr == CFG_AWIDTH'(4 + i))
                        rd_mux = param_q[i];
            end
        endcase
    end

    // mux sees pre-write state, so a same-cycle read returns the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data_q <= '0;
        else if (cfg_rd_en)
            rd_data_q <= rd_mux;
    end

    assign cfg_rd_data = rd_data_q;
    assign ctrl_enable = ctrl_enable_q;
    assign ctrl_start  = ctrl_start_q;
    assign param_out   = param_q;
endmodule

// File: tb/tb_cfg_regs.sv
// tb_cfg_regs: vector table, multi-cycle corner sequences, then random traffic
// against an address-map reference model.
module tb_cfg_regs;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] cfg_wr_data;
    logic [AW-1:0] cfg_wr_addr;
    logic          cfg_wr_en;
    logic [DW-1:0] cfg_rd_data;
    logic [AW-1:0] cfg_rd_addr;
    logic          cfg_rd_en;
    logic          ctrl_enable;
    logic          ctrl_start;
    logic          stat_busy;
    logic          stat_done;
    logic          evt_in;
    logic [NP*DW-1:0] param_out;

    int tests = 0;
    int fails = 0;

    cfg_regs #(.CFG_DWIDTH(DW), .CFG_AWIDTH(AW), .NUM_PARAM(NP)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_data(cfg_wr_data), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_en(cfg_wr_en),
        .cfg_rd_data(cfg_rd_data), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_en(cfg_rd_en),
        .ctrl_enable(ctrl_enable), .ctrl_start(ctrl_start),
        .stat_busy(stat_busy), .stat_done(stat_done), .evt_in(evt_in),
        .param_out(param_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic          busy;
        logic          done;
        logic [DW-1:0] exp_rd;
        logic          exp_en;
        logic          exp_start;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic          m_en, m_start, m_sticky;
    logic [DW-1:0] m_scr, m_evt, m_rd;
    logic [DW-1:0] m_par[NP];

    task automatic check(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra,
                         input logic busy, input logic done, input logic evt);
        cfg_wr_en = we; cfg_wr_addr = wa; cfg_wr_data = wd;
        cfg_rd_en = re; cfg_rd_addr = ra;
        stat_busy = busy; stat_done = done; evt_in = evt;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mread(input int a, input logic busy);
        if (a == 0) return {31'b0, m_en};
        if (a == 1) return {30'b0, busy, m_sticky};
        if (a == 2) return m_scr;
`ifdef CFG_REGS_EVT_CNT_EN
        if (a == 3) return m_evt;
`endif
        if (a >= 4 && a < 4 + NP) return m_par[a-4];
        return '0;
    endfunction

    task automatic model_step(input logic we, input int wa, input logic [DW-1:0] wd,
                              input logic re, input int ra,
                              input logic busy, input logic done, input logic evt);
        logic [DW-1:0] rv;
        rv = mread(ra, busy);
        if (re) m_rd = rv;
        m_start = we && wa == 0 && wd[1];
        if (we && wa == 0) m_en = wd[0];
        if (done) m_sticky = 1'b1;
        else if (we && wa == 1 && wd[0]) m_sticky = 1'b0;
        if (we && wa == 2) m_scr = wd;
        if (we && wa >= 4 && wa < 4 + NP) m_par[wa-4] = wd;
`ifdef CFG_REGS_EVT_CNT_EN
        if (re && ra == 3) m_evt = {31'b0, evt};
        else if (evt && m_evt != 32'hFFFF_FFFF) m_evt = m_evt + 32'd1;
`endif
    endtask

    function automatic logic [NP*DW-1:0] m_params();
        logic [NP*DW-1:0] p;
        for (int i = 0; i < NP; i++) p[i*DW +: DW] = m_par[i];
        return p;
    endfunction

    initial begin
        logic [NP*DW-1:0] exp_p;
        idle();
        rst = 1'b1;
        // strobes during reset must be ignored
        drive(1'b1, 5'd2, 32'hFFFF_FFFF, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
        tick(); tick();
        check("reset rd_data", cfg_rd_data, 0);
        check("reset ctrl_enable", ctrl_enable, 0);
        check("reset ctrl_start", ctrl_start, 0);
        check("reset param_out", param_out, 0);
        rst = 1'b0;
        idle();

        // we wa wd re ra busy done | rd en start
        vecs.push_back('{1'b1, 5'd0, 32'h3, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 1'b0, 32'h3, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd6, 32'hDEADBEEF, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd2, 32'h12345678, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd2, 32'hA5A5A5A5, 1'b1, 5'd2, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 5'd0, 32'h2, 1'b0, 5'd0, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 5'd0, 32'h2, 1'b0, 5'd0, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 5'd3, 32'hFFFF, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
                  vecs[i].busy, vecs[i].done, 1'b0);
            tick();
            check($sformatf("vec%0d rd_data", i), cfg_rd_data, vecs[i].exp_rd);
            check($sformatf("vec%0d ctrl_enable", i), ctrl_enable, vecs[i].exp_en);
            check($sformatf("vec%0d ctrl_start", i), ctrl_start, vecs[i].exp_start);
        end
        idle();
        exp_p = '0;
        exp_p[95:64] = 32'hDEADBEEF;
        check("param_out after PARAM2 write", param_out, exp_p);

        // event counter: pre-increment read value, clear-on-read leaves coincident event
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
`ifdef CFG_REGS_EVT_CNT_EN
        check("evt first read", cfg_rd_data, 5);
`else
        check("evt absent read", cfg_rd_data, 0);
`endif
        drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef CFG_REGS_EVT_CNT_EN
        check("evt second read", cfg_rd_data, 1);
`else
        check("evt absent second read", cfg_rd_data, 0);
`endif
        drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        check("evt third read", cfg_rd_data, 0);

        // asynchronous reset mid-cycle with a start pulse in flight
        drive(1'b1, 5'd2, 32'h12345678, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 32'h3, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check("pre-reset ctrl_start", ctrl_start, 1);
        check("pre-reset rd_data", cfg_rd_data, 32'h12345678);
        idle();
        #2 rst = 1'b1;
        #1;
        check("async rst ctrl_enable", ctrl_enable, 0);
        check("async rst ctrl_start", ctrl_start, 0);
        check("async rst rd_data", cfg_rd_data, 0);
        check("async rst param_out", param_out, 0);
        drive(1'b1, 5'd2, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        rst = 1'b0;
        idle();
        drive(1'b0, '0, '0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check("post-reset SCRATCH", cfg_rd_data, 0);
        drive(1'b0, '0, '0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
        tick();
        check("post-reset STATUS", cfg_rd_data, 0);
        drive(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        check("post-reset EVT_CNT", cfg_rd_data, 0);

        // random traffic vs model, starting from the reset state
        m_en = 0; m_start = 0; m_sticky = 0; m_scr = '0; m_evt = '0; m_rd = '0;
        for (int i = 0; i < NP; i++) m_par[i] = '0;
        for (int n = 0; n < 400; n++) begin
            logic          we, re, busy, done, evt;
            int            wa, ra;
            logic [DW-1:0] wd;
            we   = ($urandom_range(0, 2) == 0);
            re   = ($urandom_range(0, 1) == 0);
            wa   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            ra   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            wd   = $urandom;
            busy = $urandom_range(0, 1) == 1;
            done = ($urandom_range(0, 7) == 0);
            evt  = $urandom_range(0, 1) == 1;
            drive(we, AW'(wa), wd, re, AW'(ra), busy, done, evt);
            model_step(we, wa, wd, re, ra, busy, done, evt);
            tick();
            check($sformatf("rand%0d rd_data", n), cfg_rd_data, m_rd);
            check($sformatf("rand%0d ctrl_enable", n), ctrl_enable, m_en);
            check($sformatf("rand%0d ctrl_start", n), ctrl_start, m_start);
            check($sformatf("rand%0d param_out", n), param_out, m_params());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cfg_regs.md
CFG_REGS -- requirements
Module: cfg_regs

Interface
REQ-001 SHALL have parameter CFG_DWIDTH, default 32, config data width in bits.
REQ-002 SHALL have parameter CFG_AWIDTH, default 5, config word-address width.
REQ-003 SHALL have parameter NUM_PARAM, default 4, number of parameter registers; legal range 1 to 2^CFG_AWIDTH-4.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_wr_data  input  CFG_DWIDTH  write data.
REQ-007 cfg_wr_addr  input  CFG_AWIDTH  write word address.
REQ-008 cfg_wr_en  input  1  single-cycle write strobe.
REQ-009 cfg_rd_data  output  CFG_DWIDTH  registered read data.
REQ-010 cfg_rd_addr  input  CFG_AWIDTH  read word address.
REQ-011 cfg_rd_en  input  1  single-cycle read strobe.
REQ-012 ctrl_enable  output  1  level from CTRL[0].
REQ-013 ctrl_start  output  1  one-cycle pulse from CTRL[1] write.
REQ-014 stat_busy  input  1  live busy level from datapath.
REQ-015 stat_done  input  1  done pulse from datapath.
REQ-016 evt_in  input  1  event pulse, one count per high cycle.
REQ-017 param_out  output  NUM_PARAM*CFG_DWIDTH  parameter registers, PARAM[i] at bits [i*CFG_DWIDTH +: CFG_DWIDTH].

Function
REQ-018 Address map SHALL be: 0 CTRL (RW), 1 STATUS (RO + W1C), 2 SCRATCH (RW), 3 EVT_CNT (RO, clear-on-read), 4..3+NUM_PARAM PARAM[0..NUM_PARAM-1] (RW).
REQ-019 Writes SHALL take effect on the clk edge where cfg_wr_en is sampled high; unmapped or RO addresses (except STATUS W1C) SHALL be ignored.
REQ-020 CTRL write SHALL load ctrl_enable from bit 0; bit 1 = 1 SHALL drive ctrl_start high for exactly the next cycle; CTRL read SHALL return {0..., 0, ctrl_enable} (start reads 0).
REQ-021 Back-to-back CTRL writes with bit 1 set SHALL produce one ctrl_start pulse per write.
REQ-022 STATUS read SHALL return bit 0 = done_sticky, bit 1 = stat_busy (sampled at read strobe), other bits 0.
REQ-023 done_sticky SHALL set on stat_done and clear on a STATUS write with bit 0 = 1; simultaneous set and clear SHALL leave it set.
REQ-024 SCRATCH and PARAM registers SHALL be full-width RW with no side effects.
REQ-025 EVT_CNT SHALL increment on each evt_in cycle, saturate at all-ones, and clear on read of address 3.
REQ-026 Read of EVT_CNT coincident with evt_in SHALL return the pre-increment value and leave the counter at 1.
REQ-027 cfg_rd_data SHALL update on the edge after cfg_rd_en is high and hold until the next cfg_rd_en; unmapped addresses SHALL read 0.
REQ-028 Simultaneous read and write of the same address SHALL return the old value; the write SHALL complete.

Reset
REQ-029 On rst assertion, independent of clk: ctrl_enable 0, ctrl_start 0, done_sticky 0, SCRATCH 0, EVT_CNT 0, all PARAM 0, cfg_rd_data 0.
REQ-030 Strobes, stat_done and evt_in during rst SHALL be ignored; a ctrl_start pulse in flight SHALL be cancelled.

Configuration
REQ-031 Macro CFG_REGS_EVT_CNT_EN defined: EVT_CNT implemented per REQ-025/026.
REQ-032 Macro CFG_REGS_EVT_CNT_EN undefined: no counter logic, address 3 reads 0, evt_in unused, writes ignored.

Verification
REQ-033 Write CTRL=0x3 -> next cycle ctrl_enable=1, ctrl_start=1 for one cycle only; read CTRL -> 0x1.
REQ-034 Pulse stat_done, hold stat_busy=1, read STATUS -> 0x3; write STATUS=0x1 with stat_done high same cycle -> read STATUS bit 0 still 1.
REQ-035 Write PARAM[2] (addr 6)=0xDEADBEEF -> param_out[95:64]=0xDEADBEEF; read addr 6 -> 0xDEADBEEF one cycle after strobe, held until next strobe.
REQ-036 (EVT_CNT_EN) 5 evt_in pulses, then read addr 3 with evt_in high -> returns 5; second read -> returns 1; read addr 20 -> 0.
REQ-037 Write SCRATCH=0x12345678 and CTRL=0x1, assert rst mid-cycle -> all outputs 0 immediately; read SCRATCH after reset -> 0.
